// File: rtl/alu_share_arbiter.sv
// ============================================================================
// Module   : alu_share_arbiter
// Purpose  : Shares one ALU between the integer pipeline (requester 0) and the
//            branch/address unit (requester 1). Grants at most one request per
//            cycle, muxes the granted operands onto the ALU inputs and captures
//            the ALU result in a 1-deep valid/ready response slot per requester.
// Config   : ALU_ARB_RR_EN defined   -> round-robin on contention
//            ALU_ARB_RR_EN undefined -> fixed priority, requester 1 wins
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_share_arbiter #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,

  // requester 0 : integer pipeline
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_alu_op,
  input  logic             req0_d1_sel,
  input  logic             req0_d2_sel,
  input  logic [31:0]      req0_rs1_data,
  input  logic [31:0]      req0_rs2_data,
  input  logic [31:0]      req0_immediate,
  input  logic [31:0]      req0_pc,
  input  logic [TAG_W-1:0] req0_tag,

  // requester 1 : branch/address unit
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_alu_op,
  input  logic             req1_d1_sel,
  input  logic             req1_d2_sel,
  input  logic [31:0]      req1_rs1_data,
  input  logic [31:0]      req1_rs2_data,
  input  logic [31:0]      req1_immediate,
  input  logic [31:0]      req1_pc,
  input  logic [TAG_W-1:0] req1_tag,

  // response slots
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [31:0]      rsp0_data,
  output logic [TAG_W-1:0] rsp0_tag,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [31:0]      rsp1_data,
  output logic [TAG_W-1:0] rsp1_tag,

  // ALU side
  output logic [3:0]       alu_op,
  output logic             d1_sel,
  output logic             d2_sel,
  output logic [31:0]      rs1_data,
  output logic [31:0]      rs2_data,
  output logic [31:0]      immediate,
  output logic [31:0]      pc,
  input  logic [31:0]      alu_result
);

  // --------------------------------------------------------------------------
  // Requester signals gathered into index-addressable form
  // --------------------------------------------------------------------------
  logic [1:0]       req_valid;
  logic [1:0]       rsp_ready;
  logic [TAG_W-1:0] req_tag     [2];

  logic [1:0]       rsp_valid_q;
  logic [31:0]      rsp_data_q  [2];
  logic [TAG_W-1:0] rsp_tag_q   [2];

  logic [1:0]       elig;
  logic [1:0]       gnt;

  assign req_valid  = {req1_valid, req0_valid};
  assign rsp_ready  = {rsp1_ready, rsp0_ready};
  assign req_tag[0] = req0_tag;
  assign req_tag[1] = req1_tag;

  // A requester may only be granted if its response slot is free or is being
  // drained this very cycle, so a result is never dropped.
  assign elig = req_valid & (~rsp_valid_q | rsp_ready);

`ifdef ALU_ARB_RR_EN
  // --------------------------------------------------------------------------
  // Round-robin: on contention grant the requester that did not win last.
  // --------------------------------------------------------------------------
  logic last_q;
  logic last_d;

  // Grant selection; reset gates grants so the ALU sees zeros while held.
  always_comb begin
    gnt = 2'b00;
    if (elig == 2'b11) begin
      gnt = last_q ? 2'b01 : 2'b10;
    end else begin
      gnt = elig;
    end
    if (!rst_n) begin
      gnt = 2'b00;
    end
  end

  // Pointer follows the granted index; holds when nothing is granted.
  always_comb begin
    last_d = last_q;
    if (gnt[0]) begin
      last_d = 1'b0;
    end else if (gnt[1]) begin
      last_d = 1'b1;
    end
  end

  // Pointer register; reset value 1 makes requester 0 preferred first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  // --------------------------------------------------------------------------
  // Fixed priority: the branch/address unit always wins contention.
  // Requester 0 can starve while requester 1 keeps requesting.
  // --------------------------------------------------------------------------
  // Grant selection; reset gates grants so the ALU sees zeros while held.
  always_comb begin
    gnt    = 2'b00;
    gnt[1] = elig[1];
    gnt[0] = elig[0] & ~elig[1];
    if (!rst_n) begin
      gnt = 2'b00;
    end
  end
`endif

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  // --------------------------------------------------------------------------
  // ALU operand/control mux; all zero when nothing is granted
  // --------------------------------------------------------------------------
  // Drive the ALU from whichever requester holds the one-hot grant.
  always_comb begin
    alu_op    = 4'd0;
    d1_sel    = 1'b0;
    d2_sel    = 1'b0;
    rs1_data  = 32'd0;
    rs2_data  = 32'd0;
    immediate = 32'd0;
    pc        = 32'd0;
    if (gnt[1]) begin
      alu_op    = req1_alu_op;
      d1_sel    = req1_d1_sel;
      d2_sel    = req1_d2_sel;
      rs1_data  = req1_rs1_data;
      rs2_data  = req1_rs2_data;
      immediate = req1_immediate;
      pc        = req1_pc;
    end else if (gnt[0]) begin
      alu_op    = req0_alu_op;
      d1_sel    = req0_d1_sel;
      d2_sel    = req0_d2_sel;
      rs1_data  = req0_rs1_data;
      rs2_data  = req0_rs2_data;
      immediate = req0_immediate;
      pc        = req0_pc;
    end
  end

  // --------------------------------------------------------------------------
  // Per-requester 1-deep response slots (independent of each other)
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < 2; i++) begin : g_slot
    logic             valid_d;
    logic [31:0]      data_d;
    logic [TAG_W-1:0] tag_d;

    // Capture on grant (wins over a same-cycle drain); otherwise drain on
    // ready. Data and tag are only rewritten by a capture.
    always_comb begin
      valid_d = rsp_valid_q[i];
      data_d  = rsp_data_q[i];
      tag_d   = rsp_tag_q[i];
      if (gnt[i]) begin
        valid_d = 1'b1;
        data_d  = alu_result;
        tag_d   = req_tag[i];
      end else if (rsp_ready[i]) begin
        valid_d = 1'b0;
      end
    end

    // Slot registers; reset discards any pending response.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rsp_valid_q[i] <= 1'b0;
        rsp_data_q[i]  <= 32'd0;
        rsp_tag_q[i]   <= '0;
      end else begin
        rsp_valid_q[i] <= valid_d;
        rsp_data_q[i]  <= data_d;
        rsp_tag_q[i]   <= tag_d;
      end
    end
  end

  assign rsp0_valid = rsp_valid_q[0];
  assign rsp0_data  = rsp_data_q[0];
  assign rsp0_tag   = rsp_tag_q[0];
  assign rsp1_valid = rsp_valid_q[1];
  assign rsp1_data  = rsp_data_q[1];
  assign rsp1_tag   = rsp_tag_q[1];

endmodule

`default_nettype wire
